// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module rca_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_top
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout  = w_c[CHUNK];
  // Carry into the top bit; XOR with o_cout gives signed overflow.
  assign o_c_top = w_c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: WIDTH bits processed CHUNK bits per clock, LSB first,
// with valid/ready handshakes on both sides.
module seq_chunk_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);

  if (CHUNK == 0 || WIDTH % CHUNK != 0) begin : g_bad_chunk
    $fatal(1, "seq_chunk_addsub: CHUNK must be nonzero and divide WIDTH");
  end

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_c_top;
  logic [WIDTH-1:0] w_s_next;

  rca_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .i_a    (r_op_a[CHUNK-1:0]),
    .i_b    (r_op_b[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c_top(w_c_top)
  );

  // Result fills from the top so the LSB chunk lands at bit 0 after NCHUNK steps.
  if (CHUNK == WIDTH) begin : g_single
    assign w_s_next = w_sum;
  end else begin : g_multi
    assign w_s_next = {w_sum, r_s[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op_a  <= a;
            r_op_b  <= b ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_op_a  <= r_op_a >> CHUNK;
          r_op_b  <= r_op_b >> CHUNK;
          r_s     <= w_s_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NCHUNK - 1)) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c_top ^ w_cout;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
